// File: rtl/avl_max_master_pkg.sv
// Shared definitions for the max-finder bus initiator and its slave.
//   stateT         : initiator FSM state encoding
//   busStrobeT     : active-low chipselect/write/read strobe bundle
//   AVL_*_ADDR     : register map shared with the slave
//   AVL_CNT_W      : width of the read-latency counter (READ_LATENCY 1..7)
package avl_max_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD_ECHO,
        WAIT_ECHO,
        RD_RES,
        WAIT_RES,
        DONE
    } stateT;

    typedef struct packed {
        logic csN;
        logic writeN;
        logic readN;
    } busStrobeT;

    localparam busStrobeT STROBE_IDLE  = '{csN: 1'b1, writeN: 1'b1, readN: 1'b1};
    localparam busStrobeT STROBE_WRITE = '{csN: 1'b0, writeN: 1'b0, readN: 1'b1};
    localparam busStrobeT STROBE_READ  = '{csN: 1'b0, writeN: 1'b1, readN: 1'b0};

    localparam int AVL_OPERAND_ADDR = 0;
    localparam int AVL_RESULT_ADDR  = 1;

    localparam int AVL_CNT_W = 3;

endpackage

// File: rtl/avl_max_master_rd_wait_cnt.sv
// Loadable down-counter that times the read-data latency.
//   iClk, iReset_n : clock, asynchronous active-low reset
//   iLoad          : load iLoadVal (takes priority over iDec)
//   iDec           : decrement, saturating at zero
//   oLast          : counter currently holds 1 (final wait cycle)
module avl_rd_wait_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iLoad,
    input  logic [CNT_W-1:0] iLoadVal,
    input  logic             iDec,
    output logic             oLast
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            count <= '0;
        end else if (iLoad) begin
            count <= iLoadVal;
        end else if (iDec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign oLast = (count == CNT_W'(1));

endmodule

// File: rtl/avl_max_master.sv
// Bus initiator for the max-finder slave: writes the operand, reads it back
// as an echo check, reads the result, then pulses oDone for one cycle.
//   iClk, iReset_n        : clock, asynchronous active-low reset
//   iStart, iOperand      : request pulse and operand (captured on accept)
//   oBusy, oDone          : busy flag, single-cycle completion pulse
//   oResult, oEchoErr     : last result and echo-mismatch flag
//   oChipselect_n, oWrite_n, oRead_n, oAddress, oData, iData : slave bus
module avl_max_master
    import avl_max_master_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 2,
    parameter int OPERAND_W    = 20,
    parameter int OPERAND_ADDR = AVL_OPERAND_ADDR,
    parameter int RESULT_ADDR  = AVL_RESULT_ADDR,
    parameter int READ_LATENCY = 1
) (
    input  logic                 iClk,
    input  logic                 iReset_n,
    input  logic                 iStart,
    input  logic [OPERAND_W-1:0] iOperand,
    output logic                 oBusy,
    output logic                 oDone,
    output logic [DATA_W-1:0]    oResult,
    output logic                 oEchoErr,
    output logic                 oChipselect_n,
    output logic                 oWrite_n,
    output logic                 oRead_n,
    output logic [ADDR_W-1:0]    oAddress,
    output logic [DATA_W-1:0]    oData,
    input  logic [DATA_W-1:0]    iData
);

    stateT                state;
    stateT                stateNext;
    busStrobeT            strobeReg;
    busStrobeT            strobeNext;
    logic [ADDR_W-1:0]    addrNext;
    logic [DATA_W-1:0]    dataNext;
    logic [OPERAND_W-1:0] operandReg;
    logic [DATA_W-1:0]    operandExt;
    logic                 echoMis;
    logic                 cntLoad;
    logic                 cntDec;
    logic                 cntLast;

    assign operandExt = DATA_W'(operandReg);

    assign cntLoad = (state == RD_ECHO) || (state == RD_RES);
    assign cntDec  = (state == WAIT_ECHO) || (state == WAIT_RES);

    avl_rd_wait_cnt #(
        .CNT_W(AVL_CNT_W)
    ) uRdWaitCnt (
        .iClk    (iClk),
        .iReset_n(iReset_n),
        .iLoad   (cntLoad),
        .iLoadVal(AVL_CNT_W'(READ_LATENCY)),
        .iDec    (cntDec),
        .oLast   (cntLast)
    );

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:      if (iStart) stateNext = WR;
            WR:        stateNext = RD_ECHO;
            RD_ECHO:   stateNext = WAIT_ECHO;
            WAIT_ECHO: if (cntLast) stateNext = RD_RES;
            RD_RES:    stateNext = WAIT_RES;
            WAIT_RES:  if (cntLast) stateNext = DONE;
            DONE:      stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase
    end

    // Bus outputs are registered from the next state so each strobe lines up
    // with its state cycle. WR is only entered from IDLE, where operandReg is
    // being loaded on the same edge, so the write data comes from iOperand.
    always_comb begin
        strobeNext = STROBE_IDLE;
        addrNext   = '0;
        dataNext   = '0;
        case (stateNext)
            WR: begin
                strobeNext = STROBE_WRITE;
                addrNext   = ADDR_W'(OPERAND_ADDR);
                dataNext   = DATA_W'(iOperand);
            end
            RD_ECHO: begin
                strobeNext = STROBE_READ;
                addrNext   = ADDR_W'(OPERAND_ADDR);
            end
            RD_RES: begin
                strobeNext = STROBE_READ;
                addrNext   = ADDR_W'(RESULT_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            strobeReg  <= STROBE_IDLE;
            oAddress   <= '0;
            oData      <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oResult    <= '0;
            oEchoErr   <= 1'b0;
            operandReg <= '0;
            echoMis    <= 1'b0;
        end else begin
            strobeReg <= strobeNext;
            oAddress  <= addrNext;
            oData     <= dataNext;
            oBusy     <= (stateNext != IDLE);
            oDone     <= (stateNext == DONE);
            if ((state == IDLE) && iStart) begin
                operandReg <= iOperand;
            end
            if ((state == WAIT_ECHO) && cntLast) begin
                echoMis <= (iData != operandExt);
            end
            if ((state == WAIT_RES) && cntLast) begin
                oResult  <= iData;
                oEchoErr <= echoMis;
            end
        end
    end

    assign oChipselect_n = strobeReg.csN;
    assign oWrite_n      = strobeReg.writeN;
    assign oRead_n       = strobeReg.readN;

endmodule

// File: doc/avl_max_master.md
Name: avl_max_master

Overview:
Bus initiator that drives the team's memory-mapped max-finder slave, the other end of the active-low chipselect/write/read register interface.
- On a local start pulse it writes a packed 20-bit operand to the operand register.
- It reads the operand register back as an echo check, then reads the result register.
- It returns the result with a one-cycle done pulse.
- It sits between control logic (or a test sequencer) and the slave.

Parameters:
- DATA_W, 32, bus data width.
- ADDR_W, 2, bus address width.
- OPERAND_W, 20, significant operand bits. Upper DATA_W-OPERAND_W bits are written as zero.
- OPERAND_ADDR, 0, operand register address.
- RESULT_ADDR, 1, result register address.
- READ_LATENCY, 1, cycles between the read-strobe cycle and the cycle in which read data is sampled. Range 1..7.

Ports:
- iClk  in  1  system clock, rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iStart  in  1  request pulse. Sampled only in IDLE.
- iOperand  in  OPERAND_W  operand. Captured on the accepted start.
- oBusy  out  1  high from the cycle after the accepted start through the DONE cycle.
- oDone  out  1  single-cycle completion pulse.
- oResult  out  DATA_W  last result read. Held until the next completion.
- oEchoErr  out  1  echo mismatch on the last transaction. Held until the next completion.
- oChipselect_n  out  1  bus chip select, active low.
- oWrite_n  out  1  bus write strobe, active low.
- oRead_n  out  1  bus read strobe, active low.
- oAddress  out  ADDR_W  bus address.
- oData  out  DATA_W  bus write data.
- iData  in  DATA_W  bus read data from the slave.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While iReset_n is low:
  - FSM goes to IDLE; oChipselect_n, oWrite_n, oRead_n are 1.
  - oAddress, oData, oResult are 0; oBusy, oDone, oEchoErr are 0; latency counter is 0.
- All outputs are registered.
- Bus rules:
  - At most one strobe is low per cycle. oChipselect_n is low exactly in strobe cycles.
  - Every strobe lasts exactly one cycle.
  - The slave has no wait-request; read data is valid READ_LATENCY cycles after the strobe cycle.
- FSM states: IDLE, WR, RD_ECHO, WAIT_ECHO, RD_RES, WAIT_RES, DONE.
  - IDLE: when iStart=1 at the edge, capture iOperand → WR.
  - WR: cs_n=0, write_n=0, address=OPERAND_ADDR, oData = zero-extended operand → RD_ECHO.
  - RD_ECHO: cs_n=0, read_n=0, address=OPERAND_ADDR; load counter with READ_LATENCY → WAIT_ECHO.
  - WAIT_ECHO: decrement the counter. At the edge ending the cycle where the counter reaches 1, sample iData and compare with the zero-extended operand → RD_RES.
  - RD_RES: cs_n=0, read_n=0, address=RESULT_ADDR; reload counter → WAIT_RES.
  - WAIT_RES: same countdown. Sample iData into the result register, latch the echo compare into oEchoErr → DONE.
  - DONE: oDone=1 for exactly this cycle, oBusy=1 → IDLE.
- Latency with READ_LATENCY=1: start accepted at edge E0; WR is cycle 1; oDone is high in cycle 6. In general the done cycle is 4 + 2·READ_LATENCY.
- oAddress and oData return to 0 in non-strobe cycles.
- iStart while busy (including the DONE cycle) is ignored, not queued.
- iOperand changes after acceptance have no effect.
- Back-to-back operation: a start in the first IDLE cycle after DONE is accepted.
- Reset mid-transaction: strobes deassert immediately (asynchronously); the transaction is abandoned; no oDone pulse.
- oResult and oEchoErr update only on the DONE transition, never on abandonment.

Decomposition:
- Shared package: FSM state enum, OPERAND_ADDR/RESULT_ADDR constants, and the bus strobe encoding. The slave reuses the address constants.
- One natural sub-module: avl_rd_wait_cnt, a loadable down-counter for READ_LATENCY with a "last" flag. Everything else stays in the top module.

Test Plan:
All scenarios use the max-finder slave (max of five 4-bit fields) attached, READ_LATENCY=1.
1. Reset: hold iReset_n=0 for 3 cycles → all strobes 1, oResult=0, oBusy=0, oDone=0.
2. Basic transaction: iStart with iOperand=20'h19372 →
   - bus trace: write addr 0 data 32'h00019372, read addr 0, read addr 1;
   - oDone high in cycle 6, oResult=32'h9, oEchoErr=0.
3. Boundary values:
   - iOperand=20'hFFFFF → oResult=32'hF;
   - then iOperand=20'h00000 → oResult=32'h0;
   - strobes are never simultaneous.
4. Echo fault: the bench slave model corrupts the addr-0 read data to 32'h00000001 → oEchoErr=1, oResult still captured.
5. Start handling:
   - iStart held high continuously → one transaction per 7 cycles, a start re-accepted each IDLE;
   - iStart pulses during busy cycles are ignored.
6. Reset mid-transaction: reset asserted during WAIT_RES →
   - strobes high asynchronously, no oDone, oResult keeps its previous value;
   - a new start after reset completes normally.
   Repeat scenario 2 with READ_LATENCY=3 → oDone in cycle 10.
